// File: rtl/result_beat_serializer.sv
// Serializes wide result records into fixed, zero-padded slots of AXI read-data beats.
// Empty output buffer at a slot boundary yields an all-zero slot so every burst completes.
module result_beat_serializer #(
  parameter int unsigned AXI_DWIDTH  = 64,
  parameter int unsigned RESULT_SIZE = 336
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [7:0]             i_req_len,
  input  logic                   i_res_valid,
  input  logic [RESULT_SIZE-1:0] i_res_data,
  output logic                   o_res_ready,
  output logic                   o_beat_valid,
  output logic [AXI_DWIDTH-1:0]  o_beat_data,
  output logic                   o_beat_last,
  input  logic                   i_beat_ready,
  output logic [15:0]            o_empty_slots
);

  localparam int unsigned BEATS_PER_RESULT = (RESULT_SIZE + AXI_DWIDTH - 1) / AXI_DWIDTH;
  localparam int unsigned IDX_W = (BEATS_PER_RESULT > 1) ? $clog2(BEATS_PER_RESULT) : 1;
  localparam int unsigned PAD_W = BEATS_PER_RESULT * AXI_DWIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_RESULT - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [RESULT_SIZE-1:0] r_hold;
  logic [7:0]             r_beats_left;
  logic [15:0]            r_empty_slots;
  logic                   r_req_ready;
  logic                   r_beat_valid;
  logic                   r_beat_last;

  logic                                         w_slot_start;
  logic [BEATS_PER_RESULT-1:0][AXI_DWIDTH-1:0] w_pad;

  assign w_slot_start  = (r_idx == '0);
  assign w_pad         = PAD_W'(r_hold);
  assign o_req_ready   = r_req_ready;
  assign o_beat_valid  = r_beat_valid;
  assign o_beat_last   = r_beat_last;
  assign o_empty_slots = r_empty_slots;
  // Pop strictly at slot start; the zero-slot decision is made at the same handshake.
  assign o_res_ready   = r_beat_valid && w_slot_start && i_beat_ready;

  always_comb begin
    o_beat_data = '0;
    if (r_beat_valid) begin
      if (w_slot_start) begin
        o_beat_data = i_res_valid ? i_res_data[AXI_DWIDTH-1:0] : '0;
      end else begin
        o_beat_data = w_pad[r_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_hold        <= '0;
      r_beats_left  <= '0;
      r_empty_slots <= '0;
      r_req_ready   <= 1'b1;
      r_beat_valid  <= 1'b0;
      r_beat_last   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_state      <= StSend;
            r_beats_left <= i_req_len;
            r_beat_last  <= (i_req_len == 8'd0);
            r_req_ready  <= 1'b0;
            r_beat_valid <= 1'b1;
          end
        end
        StSend: begin
          if (i_beat_ready) begin
            if (r_beat_last) begin
              r_state      <= StIdle;
              r_req_ready  <= 1'b1;
              r_beat_valid <= 1'b0;
              r_beat_last  <= 1'b0;
            end else begin
              r_beats_left <= r_beats_left - 8'd1;
              r_beat_last  <= (r_beats_left == 8'd1);
            end
            // idx and hold survive across bursts so a split slot resumes where it stopped.
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            if (w_slot_start) begin
              r_hold <= i_res_valid ? i_res_data : '0;
              if (!i_res_valid && (r_empty_slots != 16'hFFFF)) begin
                r_empty_slots <= r_empty_slots + 16'd1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/result_beat_serializer.md
Name: result_beat_serializer

Overview:
- Converts RESULT_SIZE-bit result records popped from the output buffer into AXI_DWIDTH-bit read-data beats for the AXI R channel.
- Sits between output_buffer (upstream) and the AXI read-data path (downstream), and serves one read burst request at a time.
- Each result occupies a fixed slot of BEATS_PER_RESULT beats, zero-padded.
- When the buffer is empty at a slot boundary, the serializer emits an all-zero slot, so bursts always complete.

Parameters:
- AXI_DWIDTH, 64, beat width in bits.
- RESULT_SIZE, 336, result record width in bits.
- BEATS_PER_RESULT, ceil(RESULT_SIZE/AXI_DWIDTH) = 6, beats per result slot (derived localparam).
- IDX_W, clog2(BEATS_PER_RESULT) = 3, beat-index width (derived localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  burst request accepted.
- req_len  in  8  burst length minus 1 (AXI arlen encoding).
- res_valid  in  1  output buffer has a result.
- res_data  in  RESULT_SIZE  head result.
- res_ready  out  1  pop result.
- beat_valid  out  1  beat available.
- beat_data  out  AXI_DWIDTH  beat payload.
- beat_last  out  1  final beat of burst.
- beat_ready  in  1  downstream accepts beat.
- empty_slots  out  16  saturating count of zero-filled slots since reset.

Behaviour:
- Reset (rst=1 at clk edge), values hold until first non-reset edge:
  - state=IDLE, idx=0, hold=0, beats_left=0, empty_slots=0.
  - All outputs 0 except req_ready=1.
- States:
  - IDLE: req_ready=1, beat_valid=0. On req_valid: beats_left<=req_len, go to SEND next cycle. First beat is visible 1 cycle after request acceptance.
  - SEND: req_ready=0, beat_valid=1.
    - beat_last=(beats_left==0).
    - On beat handshake (beat_valid && beat_ready): if beat_last go to IDLE, else beats_left<=beats_left-1.
- Padded slot view: P = {zeros, slot} with width BEATS_PER_RESULT*AXI_DWIDTH (384).
  - Beat k of a slot is P[k*AXI_DWIDTH +: AXI_DWIDTH].
  - For RESULT_SIZE=336, beat 5 has bits [63:16] = 0.
- beat_data:
  - idx==0: res_valid ? res_data[AXI_DWIDTH-1:0] : 0 (combinational pass-through).
  - idx>0: padded hold beat idx.
- res_ready = (state==SEND) && (idx==0) && beat_ready.
  - Does not depend on res_valid; pops exactly at slot start.
- On beat handshake at idx==0:
  - hold <= res_valid ? res_data : 0.
  - If !res_valid, empty_slots increments, saturating at 0xFFFF.
- idx increments on every beat handshake and wraps BEATS_PER_RESULT-1 -> 0.
- Burst ending mid-slot (e.g. arlen=3):
  - idx and hold persist across IDLE.
  - The next burst resumes at the stored idx; no result is lost or re-popped.
- res_valid rising while idx>0 has no effect until the next slot boundary.
- beat_ready low in SEND: beat_data/beat_last stable and nothing advances. Slot-0 data may change only if res_valid rises, since the zero choice is not committed until the handshake.
- req_valid in SEND is ignored (req_ready=0); the request stays pending.
- rst asserted mid-burst: immediate return to reset values and idx=0. A partially sent hold is discarded, and the upstream pop already happened.

Test Plan:
- Single slot: reset, 1 result with res_data = 336'h1..., req_len=5 → 6 beats; beat0 = bits[63:0], beat5 = {48'h0, bits[335:320]}. beat_last only on beat5, res_ready pulses once at beat0, idle afterwards.
- Empty buffer: res_valid=0, req_len=11 → 12 beats all 0; empty_slots=2; res_ready asserted at beats 0 and 6.
- Split slot across bursts: results A,B queued, req_len=3 then req_len=7 → burst1 = A beats 0-3; burst2 = A beats 4-5 then B beats 0-5. Exactly 2 pops total.
- Backpressure: beat_ready toggles 1,0,0,1 each beat over a 6-beat burst → data stable while stalled, no skipped or duplicated beats, single pop.
- Late data: res_valid=0 at slot start, rises at idx=2 → slot zero-filled, empty_slots+1, result popped at the next slot start.
- Reset mid-burst: rst at beat 3 of a 6-beat burst → next cycle beat_valid=0, req_ready=1, empty_slots=0. New req_len=5 starts at idx 0.
